// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one 8-bit sequential ALU between two requesters.
// Define ALU_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TO_CYCLES cycles.
module alu_arbiter #(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y0,
    input  logic [7:0]  y1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] res0,
    output logic [15:0] res1,
    output logic        err,
    output logic        busy,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_inbus,
    input  logic [15:0] alu_outbus,
    input  logic        alu_done
);
    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d, last_q, last_d;
    logic [15:0] res_q, res_d;
    logic        expired;

    if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to
        $error("TO_CYCLES must be in 1..255");
    end

`ifdef ALU_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Counter holds k-1 in the k-th WAIT cycle, so the limit cycle is WAIT cycle TO_CYCLES.
    assign expired = state_q == WAIT && cnt_q == 8'(TO_CYCLES - 1);
    assign cnt_d   = state_q == LOAD_Y ? 8'd0 : state_q == WAIT ? cnt_q + 8'd1 : cnt_q;
    assign err_d   = state_q == WAIT ? !alu_done && expired : err_q;
    assign err     = state_q == RESP && err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                gnt_d   = (req0 && req1) ? ~last_q : req1;
                state_d = LOAD_X;
            end
            LOAD_X: state_d = LOAD_Y;
            LOAD_Y: state_d = WAIT;
            WAIT: if (alu_done || expired) begin
                res_d   = alu_done ? alu_outbus : 16'hFFFF;
                last_d  = gnt_q;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            res_q   <= res_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign alu_start = state_q == LOAD_X;
    assign alu_inbus = state_q == LOAD_X ? (gnt_q ? x1 : x0) :
                       state_q == LOAD_Y ? (gnt_q ? y1 : y0) : 8'h00;
    assign alu_op    = (state_q == LOAD_X || state_q == LOAD_Y || state_q == WAIT) ?
                       (gnt_q ? op1 : op0) : 2'b00;
    assign ack0      = state_q == RESP && !gnt_q;
    assign ack1      = state_q == RESP && gnt_q;
    assign res0      = ack0 ? res_q : 16'h0000;
    assign res1      = ack1 ? res_q : 16'h0000;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus, a sequential-ALU responder, and a job-timeline model
// checked against every output on every falling edge.
module tb_alu_arbiter;
    localparam int TO = 10;
`ifdef ALU_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 0, rst = 0, req0 = 0, req1 = 0;
    logic [1:0]  op0 = 0, op1 = 0;
    logic [7:0]  x0 = 0, y0 = 0, x1 = 0, y1 = 0;
    logic        ack0, ack1, err, busy, alu_start;
    logic [15:0] res0, res1;
    logic [1:0]  alu_op;
    logic [7:0]  alu_inbus;
    logic        m_done = 0, s_done = 0;
    logic [15:0] m_out = 16'h5A5A;
    logic        alu_done;
    logic [15:0] alu_outbus;

    assign alu_done   = m_done | s_done;
    assign alu_outbus = s_done ? 16'hBEEF : m_out;

    alu_arbiter #(.TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .ack0(ack0), .ack1(ack1),
        .res0(res0), .res1(res1), .err(err), .busy(busy), .alu_start(alu_start),
        .alu_op(alu_op), .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Sequential ALU: op 0 add, 1 multiply, 2 subtract, 3 xor; done after a_lat WAIT cycles (0 = never).
    function automatic logic [15:0] alu_f(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        return o == 2'd0 ? 16'(a) + 16'(b) : o == 2'd1 ? 16'(a) * 16'(b) :
               o == 2'd2 ? 16'(a) - 16'(b) : {8'h00, a ^ b};
    endfunction

    int a_lat = 3, a_stage = 0, a_w = 0, a_starts = 0, wait_cyc = 0, done_cyc = 0;
    logic [7:0] a_x = 0, a_y = 0;
    logic [1:0] a_op = 0;

    always begin : alu_model
        logic st, ak, r;
        logic [7:0] ib;
        logic [1:0] o;
        @(negedge clk);
        st = alu_start; ib = alu_inbus; o = alu_op; ak = ack0 | ack1; r = rst;
        #1;
        m_done = 0;
        if (!r) a_stage = 0;
        else if (st) begin a_x = ib; a_op = o; a_stage = 1; a_starts++; end
        else if (a_stage == 1) begin a_y = ib; a_stage = 2; a_w = 0; end
        else if (a_stage == 2) begin
            if (ak) a_stage = 0;
            else begin
                a_w++;
                if (a_w == 1) wait_cyc = cyc;
                if (a_lat != 0 && a_w == a_lat) begin
                    m_done = 1; m_out = alu_f(a_op, a_x, a_y); done_cyc = cyc; a_stage = 0;
                end
            end
        end
    end

    // Job timeline model: m_t = cycles since grant (0 = idle), m_dt = cycle the job completed.
    int m_t, m_dt;
    logic m_g, m_last, m_terr;
    logic [15:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t <= 0; m_dt <= 0; m_g <= 0; m_last <= 1; m_terr <= 0; m_res <= 0;
        end else if (m_t == 0) begin
            if (req0 || req1) begin
                m_g <= (req0 && req1) ? !m_last : req1;
                m_t <= 1; m_dt <= 0; m_terr <= 0;
            end
        end else if (m_dt != 0 && m_t == m_dt + 1) begin
            m_last <= m_g; m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t >= 3 && m_dt == 0 && alu_done) begin
                m_dt <= m_t; m_res <= alu_outbus;
            end else if (TO_EN && m_t >= 3 && m_dt == 0 && m_t - 2 == TO) begin
                m_dt <= m_t; m_res <= 16'hFFFF; m_terr <= 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic resp;
        logic [7:0] ex_in;
        resp  = m_dt != 0 && m_t == m_dt + 1;
        ex_in = m_t == 1 ? (m_g ? x1 : x0) : m_t == 2 ? (m_g ? y1 : y0) : 8'h00;
        chk("busy", busy, m_t != 0);
        chk("alu_start", alu_start, m_t == 1);
        chk("alu_inbus", alu_inbus, ex_in);
        chk("alu_op", alu_op, (m_t != 0 && !resp) ? (m_g ? op1 : op0) : 2'b00);
        chk("ack0", ack0, resp && !m_g);
        chk("ack1", ack1, resp && m_g);
        chk("res0", res0, (resp && !m_g) ? m_res : 16'h0000);
        chk("res1", res1, (resp && m_g) ? m_res : 16'h0000);
        chk("err", err, resp && m_terr);
    end

    int ack_id[$], ack_cyc[$];
    logic [15:0] ack_res[$];
    logic ack_err[$];

    always @(negedge clk) if (ack0 | ack1) begin
        ack_id.push_back(ack1 ? 1 : 0); ack_res.push_back(ack1 ? res1 : res0);
        ack_err.push_back(err); ack_cyc.push_back(cyc);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (ack_id.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chk("ack_arrived", ack_id.size() >= n, 1);
    endtask

    task automatic wait_start(input int budget);
        int k = 0;
        while (!alu_start && k < budget) begin @(negedge clk); #1; k++; end
        chk("start_arrived", alu_start, 1);
    endtask

    initial begin
        int n, s0;
        rst = 0; req0 = 1; op0 = 2'd0; x0 = 8'h12; y0 = 8'h34; a_lat = 3;
        cycles(3);
        chk("rst_busy", busy, 0);
        chk("rst_start", alu_start, 0);
        rst = 1;
        cycles(1);
        chk("first_start", alu_start, 1);
        chk("first_x", alu_inbus, 8'h12);
        cycles(1);
        chk("first_y", alu_inbus, 8'h34);
        wait_acks(1, 20);
        req0 = 0;
        chk("job1_id", ack_id[0], 0);
        chk("job1_res", ack_res[0], 16'h0046);
        chk("job1_lat", ack_cyc[0], done_cyc + 1);
        cycles(1);
        chk("job1_idle", busy, 0);

        s_done = 1;
        cycles(1);
        s_done = 0;
        chk("spur_idle_noack", ack_id.size(), 1);
        req0 = 1;
        wait_start(10);
        cycles(1);
        s_done = 1;
        cycles(1);
        s_done = 0;
        wait_acks(2, 20);
        req0 = 0;
        chk("spur_loady_res", ack_res[1], 16'h0046);

        rst = 0;
        cycles(2);
        req0 = 1; req1 = 1; op1 = 2'd1; x1 = 8'h40; y1 = 8'h30; a_lat = 2;
        cycles(1);
        rst = 1;
        wait_acks(6, 60);
        req0 = 0; req1 = 0;
        chk("rr_id0", ack_id[2], 0);
        chk("rr_id1", ack_id[3], 1);
        chk("rr_id2", ack_id[4], 0);
        chk("rr_id3", ack_id[5], 1);
        chk("rr_res0", ack_res[2], 16'h0046);
        chk("rr_res1", ack_res[3], 16'h0C00);
        chk("rr_res3", ack_res[5], 16'h0C00);

        cycles(1);
        req1 = 1; a_lat = 0; s0 = a_starts;
        wait_start(10);
        cycles(3);
        rst = 0;
        n = ack_id.size();
        cycles(2);
        chk("abort_busy", busy, 0);
        chk("abort_noack", ack_id.size(), n);
        rst = 1; a_lat = 2;
        wait_acks(n + 1, 30);
        req1 = 0;
        chk("abort_regrant_id", ack_id[n], 1);
        chk("abort_regrant_res", ack_res[n], 16'h0C00);
        chk("abort_restart", a_starts, s0 + 2);
        chk("abort_x", a_x, 8'h40);

`ifdef ALU_ARB_TIMEOUT_EN
        cycles(1);
        req0 = 1; a_lat = 0; n = ack_id.size();
        wait_acks(n + 1, 40);
        req0 = 0;
        chk("to_res", ack_res[n], 16'hFFFF);
        chk("to_err", ack_err[n], 1);
        chk("to_cycle", ack_cyc[n], wait_cyc + TO);
        cycles(1);
        req0 = 1; a_lat = TO;
        wait_acks(n + 2, 40);
        req0 = 0;
        chk("limit_res", ack_res[n + 1], 16'h0046);
        chk("limit_err", ack_err[n + 1], 0);
        chk("limit_done", done_cyc, wait_cyc + TO - 1);
`endif
        cycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
